// File: rtl/usb_gpx_pkg.sv
// Shared constants for the MAX3421E GPX front-end: register map and edge-select modes.
package usb_gpx_pkg;

   localparam logic [1:0] GPX_ADDR_DATA = 2'd0;
   localparam logic [1:0] GPX_ADDR_MASK = 2'd1;
   localparam logic [1:0] GPX_ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/gpx_glitch_filter.sv
// Synchroniser chain followed by a stability counter; q_clean only follows the
// synchronised input after it has held a new level for FILTER_CYCLES cycles.
module gpx_glitch_filter #(
   parameter int SYNC_STAGES   = 2,   // legal range 2..4
   parameter int FILTER_CYCLES = 4    // 0 bypasses the counter
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_async,
   output logic q_clean
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d_async};
      end
   end

   assign sync_q = sync_r[SYNC_STAGES-1];

   generate
      if (FILTER_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               q_clean <= 1'b0;
            end else begin
               q_clean <= sync_q;
            end
         end
      end else begin : g_filter
         localparam int CW = $clog2(FILTER_CYCLES + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

         logic [CW-1:0] cnt;

         // Any return to the current output level restarts the stability count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt     <= '0;
               q_clean <= 1'b0;
            end else if (sync_q == q_clean) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               q_clean <= sync_q;
               cnt     <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner: clean level for the PIO, sticky edge capture and a
// maskable level IRQ behind a small Avalon-MM slave.
module usb_gpx_conditioner
   import usb_gpx_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int EDGE_MODE     = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        gpx_pin,
   input  logic [1:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        gpx_clean
);

   logic prev;
   logic rise;
   logic fall;
   logic ev;
   logic edge_capture;
   logic irq_mask;
   logic edge_clr;
   logic rd_bit;
   logic wdata_unused;

   gpx_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .d_async (gpx_pin),
      .q_clean (gpx_clean)
   );

   assign wdata_unused = ^writedata[31:1];

   assign rise = gpx_clean & ~prev;
   assign fall = ~gpx_clean & prev;

   always_comb begin
      ev = rise;
      case (EDGE_MODE)
         EDGE_RISE: ev = rise;
         EDGE_FALL: ev = fall;
         EDGE_BOTH: ev = rise | fall;
         default:   ev = rise;
      endcase
   end

   // Avalon-MM slave, no waitrequest: a write is taken on any clk edge where
   // write is high; readdata shows the address sampled at the previous edge.
   assign edge_clr = write && (address == GPX_ADDR_EDGE) && writedata[0];

   always_comb begin
      rd_bit = 1'b0;
      case (address)
         GPX_ADDR_DATA: rd_bit = gpx_clean;
         GPX_ADDR_MASK: rd_bit = irq_mask;
         GPX_ADDR_EDGE: rd_bit = edge_capture;
         default:       rd_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev         <= 1'b0;
         edge_capture <= 1'b0;
         irq_mask     <= 1'b0;
         irq          <= 1'b0;
         readdata     <= '0;
      end else begin
         prev <= gpx_clean;
         // A new edge in the clearing cycle must not be lost.
         if (ev) begin
            edge_capture <= 1'b1;
         end else if (edge_clr) begin
            edge_capture <= 1'b0;
         end
         if (write && (address == GPX_ADDR_MASK)) begin
            irq_mask <= writedata[0];
         end
         irq      <= edge_capture & irq_mask;
         readdata <= {31'b0, rd_bit};
      end
   end

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed bench for usb_gpx_conditioner: filter latency, glitch rejection,
// edge capture, IRQ masking, set-vs-clear priority and asynchronous reset.
module tb_usb_gpx_conditioner;

   logic        clk;
   logic        reset_n;
   logic        gpx_pin;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        gpx_clean;

   logic        gpx_pin_f;
   logic [1:0]  address_f;
   logic        write_f;
   logic [31:0] writedata_f;
   logic [31:0] readdata_f;
   logic        irq_f;
   logic        gpx_clean_f;

   logic [31:0] exp_q[$];
   int          compared;
   int          mismatched;
   logic        saw_high;

   usb_gpx_conditioner u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .gpx_pin   (gpx_pin),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq),
      .gpx_clean (gpx_clean)
   );

   usb_gpx_conditioner #(.EDGE_MODE(1)) u_dut_fall (
      .clk       (clk),
      .reset_n   (reset_n),
      .gpx_pin   (gpx_pin_f),
      .address   (address_f),
      .write     (write_f),
      .writedata (writedata_f),
      .readdata  (readdata_f),
      .irq       (irq_f),
      .gpx_clean (gpx_clean_f)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick();
      write     = 1'b0;
      writedata = '0;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] e;
      exp_q.push_back(exp);
      address = a;
      tick();
      e = exp_q.pop_front();
      check(tag, readdata, e);
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      reset_n     = 1'b0;
      gpx_pin     = 1'b0;
      address     = 2'd0;
      write       = 1'b0;
      writedata   = '0;
      gpx_pin_f   = 1'b0;
      address_f   = 2'd3;
      write_f     = 1'b0;
      writedata_f = '0;

      // reset state
      repeat (3) tick();
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_clean", {31'b0, gpx_clean}, 32'h0);
      reset_n = 1'b1;
      repeat (2) tick();
      read_check("rd_data_after_rst", 2'd0, 32'h0000_0000);

      // clean step: gpx_clean rises exactly 6 edges after the pin step
      gpx_pin = 1'b1;
      repeat (5) tick();
      check("step_clean_edge5", {31'b0, gpx_clean}, 32'h0);
      tick();
      check("step_clean_edge6", {31'b0, gpx_clean}, 32'h1);
      repeat (4) tick();
      read_check("step_edge_cap", 2'd3, 32'h0000_0001);
      check("step_irq_masked", {31'b0, irq}, 32'h0);
      read_check("step_rd_data", 2'd0, 32'h0000_0001);

      // clear, then falling edge must not be captured in rising mode
      write_reg(2'd3, 32'h1);
      read_check("clr_edge_cap", 2'd3, 32'h0);
      gpx_pin = 1'b0;
      repeat (12) tick();
      check("fall_clean_low", {31'b0, gpx_clean}, 32'h0);
      read_check("fall_not_captured", 2'd3, 32'h0);

      // glitches of 1..3 cycles are rejected
      for (int w = 1; w <= 3; w++) begin
         gpx_pin = 1'b1;
         repeat (w) tick();
         gpx_pin = 1'b0;
         saw_high = 1'b0;
         repeat (14) begin
            tick();
            saw_high = saw_high | gpx_clean;
         end
         check($sformatf("glitch%0d_clean", w), {31'b0, saw_high}, 32'h0);
         read_check($sformatf("glitch%0d_cap", w), 2'd3, 32'h0);
      end

      // a 4-cycle pulse passes
      gpx_pin = 1'b1;
      repeat (4) tick();
      gpx_pin = 1'b0;
      saw_high = 1'b0;
      repeat (14) begin
         tick();
         saw_high = saw_high | gpx_clean;
      end
      check("pulse4_seen", {31'b0, saw_high}, 32'h1);
      check("pulse4_back_low", {31'b0, gpx_clean}, 32'h0);
      read_check("pulse4_cap", 2'd3, 32'h1);
      write_reg(2'd3, 32'h1);
      read_check("pulse4_cleared", 2'd3, 32'h0);

      // unmasked IRQ: asserts one edge after edge_capture
      write_reg(2'd1, 32'h1);
      read_check("mask_readback", 2'd1, 32'h1);
      address = 2'd3;
      gpx_pin = 1'b1;
      repeat (7) tick();
      check("irq_edge7", {31'b0, irq}, 32'h0);
      check("cap_view_edge7", readdata, 32'h0);
      tick();
      check("irq_edge8", {31'b0, irq}, 32'h1);
      check("cap_view_edge8", readdata, 32'h1);
      write_reg(2'd3, 32'h0);
      check("w0_irq_held", {31'b0, irq}, 32'h1);
      read_check("w0_cap_held", 2'd3, 32'h1);
      write_reg(2'd3, 32'h1);
      check("clr_irq_same", {31'b0, irq}, 32'h1);
      tick();
      check("clr_irq_next", {31'b0, irq}, 32'h0);
      check("clr_cap_view", readdata, 32'h0);
      write_reg(2'd2, 32'h1);
      read_check("rsvd_reads0", 2'd2, 32'h0);
      write_reg(2'd0, 32'h0);
      read_check("ro_data_kept", 2'd0, 32'h1);
      read_check("ro_mask_kept", 2'd1, 32'h1);

      // set and clear in the same cycle: set wins
      gpx_pin = 1'b0;
      repeat (12) tick();
      check("pre_same_low", {31'b0, gpx_clean}, 32'h0);
      read_check("pre_same_cap", 2'd3, 32'h0);
      gpx_pin = 1'b1;
      repeat (6) tick();
      write_reg(2'd3, 32'h1);
      read_check("same_cycle_cap", 2'd3, 32'h1);
      check("same_cycle_irq", {31'b0, irq}, 32'h1);

      // EDGE_MODE=1 instance: rising ignored, falling captured
      gpx_pin_f = 1'b1;
      repeat (12) tick();
      check("fmode_rise_ignored", readdata_f, 32'h0);
      gpx_pin_f = 1'b0;
      repeat (12) tick();
      check("fmode_fall_captured", readdata_f, 32'h1);

      // asynchronous reset mid-count with irq high
      gpx_pin = 1'b0;
      repeat (3) tick();
      check("pre_rst_irq", {31'b0, irq}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_irq", {31'b0, irq}, 32'h0);
      check("arst_clean", {31'b0, gpx_clean}, 32'h0);
      check("arst_readdata", readdata, 32'h0);
      check("arst_readdata_f", readdata_f, 32'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (15) tick();
      check("post_rst_irq", {31'b0, irq}, 32'h0);
      read_check("post_rst_cap", 2'd3, 32'h0);
      read_check("post_rst_mask", 2'd1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/usb_gpx_conditioner.md
Name: usb_gpx_conditioner

Overview:
- Front-end for the MAX3421E GPX pin. Sits directly upstream of the 1-bit GPX PIO input port.
- Synchronises the asynchronous pin, rejects glitches and produces a clean level (gpx_clean) that drives the PIO in_port.
- Also latches selected edges into a sticky capture bit, with a maskable IRQ, on its own small Avalon-MM slave so software need not poll.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- FILTER_CYCLES, 4, consecutive stable cycles required before gpx_clean changes; 0 = filter bypassed.
- EDGE_MODE, 0, edges to capture: 0 rising, 1 falling, 2 both.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- gpx_pin  in  1  raw GPX pin from the USB controller, asynchronous to clk.
- address  in  2  Avalon word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data; only bit 0 is used.
- readdata  out  32  Avalon read data, registered.
- irq  out  1  level interrupt to the CPU.
- gpx_clean  out  1  filtered level; feeds the GPX PIO in_port.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. During reset, all of the following are 0:
  - sync chain, filter counter, gpx_clean, edge_capture, irq_mask, readdata, irq.
- Synchroniser: an SYNC_STAGES-deep flop chain on gpx_pin; its last stage is sync_q.
- Glitch filter, FILTER_CYCLES > 0:
  - cnt has width $clog2(FILTER_CYCLES+1).
  - If sync_q == gpx_clean, cnt <= 0.
  - Else, if cnt == FILTER_CYCLES-1: gpx_clean <= sync_q and cnt <= 0.
  - Else cnt <= cnt+1.
  - A pulse shorter than FILTER_CYCLES cycles never reaches gpx_clean.
- Glitch filter, FILTER_CYCLES == 0: gpx_clean <= sync_q.
- Latency from a gpx_pin step to gpx_clean is SYNC_STAGES + FILTER_CYCLES cycles (exact for a clean step; ±1 cycle for metastable sampling).
- Edge detect:
  - prev <= gpx_clean every cycle.
  - rise = gpx_clean & ~prev; fall = ~gpx_clean & prev.
  - ev is selected from rise/fall per EDGE_MODE.
- Register map (readdata is updated every cycle with the addressed value; reads have 1-cycle latency and no side effects):
  - 0: bit0 = gpx_clean; read-only, writes ignored.
  - 1: bit0 = irq_mask; read/write.
  - 2: reserved; reads 0, writes ignored.
  - 3: bit0 = edge_capture; write 1 to clear, writing 0 has no effect.
  - Upper 31 bits always read 0.
- edge_capture:
  - Set by ev; cleared by write to address 3 with writedata[0]=1.
  - If set and clear happen in the same cycle, set wins and the bit stays 1.
- irq is registered: irq <= edge_capture & irq_mask. It asserts 1 cycle after both are 1 and deasserts 1 cycle after a clear or unmask.
- Writes to unmapped or read-only addresses change no state.
- A reset asserted mid-filter or mid-IRQ returns all state to reset values immediately, without waiting for clk.
- After reset release, a pin already high produces a rising edge once it has passed sync + filter; that edge is captured (intended: reports GPX asserted at boot).

Decomposition:
- Shared package usb_gpx_pkg holds:
  - register address constants GPX_ADDR_DATA=0, GPX_ADDR_MASK=1, GPX_ADDR_EDGE=3;
  - edge-mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
- One sub-module, gpx_glitch_filter: sync chain plus stability counter; parameters SYNC_STAGES and FILTER_CYCLES; ports clk, reset_n, d_async, q_clean.
- The top level holds edge detect, registers, readdata mux and irq.

Test Plan:
- Reset with gpx_pin=0, then release -> readdata=0, irq=0, gpx_clean=0; a read of address 0 returns 0x00000000.
- Defaults: gpx_pin 0→1 held 10 cycles -> gpx_clean rises exactly 6 cycles after the pin step. Then read address 3 -> 0x00000001.
- gpx_pin high pulses of 1, 2 and 3 cycles (FILTER_CYCLES=4) -> gpx_clean stays 0, edge_capture stays 0. A 4-cycle-stable pulse -> gpx_clean pulses high.
- Write 1 to address 1, then generate a rising edge -> irq=1 one cycle after edge_capture=1. Write 0x1 to address 3 -> irq=0 the following cycle. Writing 0x0 to address 3 leaves the bit set.
- A write-1-clear to address 3 in the same cycle a rising edge is detected -> edge_capture reads 1 afterwards. With EDGE_MODE=1, a rising edge is not captured and a falling edge is.
- Assert reset_n low mid-count, between clk edges, with irq=1 -> irq, gpx_clean and readdata go to 0 asynchronously. After release, a held-low pin produces no capture.
